// File: rtl/sr_arb_pkg.sv
// Shared types and defaults for the SR-style grant arbiter.
// State encodings and default sizing constants.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_CW       = 8;

endpackage

// File: rtl/sr_grant_arbiter_rr_pick.sv
// Combinational round-robin winner select.
// Rotates req so ptr lands at bit 0, picks the lowest set bit, rotates back.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] win
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  idx;
    logic [IW:0]    sum;

    // rotate right by ptr so the search starts at the pointer
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
    end

    // fixed-priority pick on the rotated vector, then map back modulo N
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        sum = {1'b0, idx} + {1'b0, ptr};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        win = sum[IW-1:0];
    end

endmodule

// File: rtl/sr_grant_arbiter.sv
// Round-robin arbiter whose grant bits act as SR flip-flops.
// Set on an arbitration win, reset on release or hold-time watchdog.
module sr_grant_arbiter
    import sr_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CW       = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout
);

    localparam int IW = $clog2(N);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          to_q, to_d;

    logic          found;
    logic [IW-1:0] win;
    logic          wd_fire;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .found(found),
        .win  (win)
    );

    assign wd_fire = (MAX_HOLD != 0) && (hold_q == CW'(MAX_HOLD));

    // next-state, grant set/reset and hold counter
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
                    owner_d = win;
                    ptr_d   = (win == IW'(N - 1)) ? '0 : win + IW'(1);
                    hold_d  = CW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = TURN;
                end else if (wd_fire) begin
                    gnt_d   = '0;
                    to_d    = 1'b1;
                    state_d = TURN;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers; reset drops the grant without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = |gnt_q;
    assign owner   = owner_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_sr_grant_arbiter.sv
// Scoreboard bench for sr_grant_arbiter (N=4, MAX_HOLD=8).
// A behavioural model pushes expected outputs; they are popped after each edge.
module tb_sr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;

    always #5 clk = ~clk;

    sr_grant_arbiter #(
        .N(4),
        .MAX_HOLD(8),
        .CW(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .busy   (busy),
        .owner  (owner),
        .timeout(timeout)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int         m_state, m_ptr, m_owner, m_hold;
    logic [3:0] m_gnt;
    logic       m_to;

    logic [3:0] prev_gnt;
    int         grant_log[$];
    int         run_len[$];
    int         gap_len[$];
    int         cur_run, cur_gap, to_cnt;
    bit         seen_grant;

    task automatic chk_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_owner = 0; m_hold = 0;
        m_gnt = 4'b0; m_to = 1'b0;
        prev_gnt = 4'b0; cur_run = 0; cur_gap = 0; to_cnt = 0;
        seen_grant = 1'b0;
        sb.delete();
        grant_log.delete();
        run_len.delete();
        gap_len.delete();
    endtask

    task automatic step(input logic [3:0] r);
        exp_t e;
        int   w;
        bit   f;
        req  = r;
        m_to = 1'b0;
        case (m_state)
            0: begin
                f = 1'b0;
                w = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!f && r[(m_ptr + k) % 4]) begin
                        f = 1'b1;
                        w = (m_ptr + k) % 4;
                    end
                end
                if (f) begin
                    m_gnt = 4'b0001 << w;
                    m_owner = w;
                    m_ptr = (w + 1) % 4;
                    m_hold = 1;
                    m_state = 1;
                end
            end
            1: begin
                if (!r[m_owner]) begin
                    m_gnt = 4'b0; m_state = 2;
                end else if (m_hold == 8) begin
                    m_gnt = 4'b0; m_to = 1'b1; m_state = 2;
                end else begin
                    m_hold++;
                end
            end
            default: m_state = 0;
        endcase
        e.gnt = m_gnt;
        e.busy = |m_gnt;
        e.owner = 2'(m_owner);
        e.to = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk_eq("gnt", 32'(gnt), 32'(e.gnt));
            chk_eq("busy", 32'(busy), 32'(e.busy));
            chk_eq("owner", 32'(owner), 32'(e.owner));
            chk_eq("timeout", 32'(timeout), 32'(e.to));
        end
        if (timeout) to_cnt++;
        if (gnt != 4'b0) begin
            if (prev_gnt == 4'b0) begin
                grant_log.push_back(int'(owner));
                if (seen_grant) gap_len.push_back(cur_gap);
                seen_grant = 1'b1;
            end
            cur_run++;
            cur_gap = 0;
        end else begin
            if (prev_gnt != 4'b0) begin
                run_len.push_back(cur_run);
                cur_run = 0;
            end
            cur_gap++;
        end
        prev_gnt = gnt;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_eq("rst_gnt", 32'(gnt), 32'd0);
            chk_eq("rst_busy", 32'(busy), 32'd0);
            chk_eq("rst_owner", 32'(owner), 32'd0);
            chk_eq("rst_timeout", 32'(timeout), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int   exp_seq[5];
        logic [3:0] r;
        exp_seq = '{0, 1, 2, 3, 0};
        model_reset();
        @(negedge clk);

        // 1: reset with all requesting, then first grant to 0
        do_reset(4'b1111);
        step(4'b1111);
        chk_eq("t1_first_gnt", 32'(gnt), 32'h1);

        // 2: single requester holds 3 grant cycles
        repeat (3) step(4'b0000);
        grant_log.delete();
        run_len.delete();
        repeat (3) step(4'b0100);
        repeat (3) step(4'b0000);
        chk_eq("t2_owner", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd2);
        chk_eq("t2_len", 32'(run_len.size() > 0 ? run_len[0] : -1), 32'd3);

        // 3: rotation with release after two grant cycles
        do_reset(4'b0000);
        repeat (20) begin
            if (m_state == 1 && m_hold == 2)
                r = 4'b1111 & ~(4'b0001 << m_owner);
            else
                r = 4'b1111;
            step(r);
        end
        chk_eq("t3_count", 32'(grant_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size())
                chk_eq($sformatf("t3_seq%0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));
        for (int i = 0; i < gap_len.size(); i++)
            chk_eq($sformatf("t3_gap%0d", i), 32'(gap_len[i]), 32'd2);

        // 4a: watchdog on a lone requester
        do_reset(4'b0000);
        repeat (16) step(4'b0010);
        chk_eq("t4_len", 32'(run_len.size() > 0 ? run_len[0] : -1), 32'd8);
        chk_eq("t4_to_cnt", 32'(to_cnt), 32'd1);
        chk_eq("t4_regrants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2)
            chk_eq("t4_regrant_owner", 32'(grant_log[1]), 32'd1);

        // 4b: watchdog fairness with two requesters
        do_reset(4'b0000);
        step(4'b0010);
        repeat (24) step(4'b0011);
        chk_eq("t4b_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            chk_eq("t4b_g0", 32'(grant_log[0]), 32'd1);
            chk_eq("t4b_g1", 32'(grant_log[1]), 32'd0);
            chk_eq("t4b_g2", 32'(grant_log[2]), 32'd1);
        end
        chk_eq("t4b_to_cnt", 32'(to_cnt), 32'd2);

        // 5: asynchronous reset between edges while granted to 3
        do_reset(4'b0000);
        step(4'b1000);
        step(4'b1000);
        chk_eq("t5_pre_gnt", 32'(gnt), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("t5_async_gnt", 32'(gnt), 32'd0);
        chk_eq("t5_async_busy", 32'(busy), 32'd0);
        chk_eq("t5_async_owner", 32'(owner), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(4'b1001);
        chk_eq("t5_after_gnt", 32'(gnt), 32'h1);

        // 6: other request changes are ignored during a grant
        do_reset(4'b0000);
        step(4'b0010);
        repeat (3) step(4'b1110);
        chk_eq("t6_held", 32'(gnt), 32'h2);
        repeat (4) step(4'b1100);
        chk_eq("t6_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2)
            chk_eq("t6_next", 32'(grant_log[1]), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_grant_arbiter.md
Name: sr_grant_arbiter

Overview:
- Round-robin arbiter sharing one flip-flop-controlled resource between N requesters.
- Each grant bit behaves like an SR flip-flop: set on an arbitration win, reset on release or timeout.
- Sits in front of any shared single-owner resource, such as a flag register or an output driver, in the flip-flop/sequential exercises.
- Adds a hold-time watchdog so no requester can own the resource forever.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release; 0 disables the watchdog.
- CW, 8, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i is held high by requester i while it wants the resource.
- gnt  output  N  one-hot-or-zero grant vector, registered.
- busy  output  1  high while any gnt bit is set.
- owner  output  $clog2(N)  index of current or last grantee, registered.
- timeout  output  1  one-cycle pulse on a watchdog preemption.

Behaviour:
Reset:
- rst=1 asynchronously forces: gnt=0, busy=0, owner=0, timeout=0, rr pointer ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant drops gnt immediately, without waiting for a clock edge.

States: IDLE, GRANT, TURN (turnaround).

IDLE:
- If req != 0, select the winner w = first set bit of req, searching from index ptr upward and wrapping modulo N.
- On the next edge: gnt = 1<<w, owner = w, ptr = (w+1) mod N, hold_cnt = 1, state = GRANT.
- Latency: req seen in IDLE at edge k produces gnt high after edge k.
- If req == 0, stay in IDLE with gnt = 0.

GRANT:
- Release: if req[owner]=0 at an edge, gnt=0 after that edge and state=TURN.
- Watchdog: else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD, then gnt=0, timeout=1 for exactly one cycle, state=TURN.
- Otherwise: gnt is held, hold_cnt increments; the counter saturates and never wraps.
- Changes on other req bits during GRANT are ignored; there is no preemption by priority.

TURN:
- Exactly one cycle with gnt=0, then state=IDLE.
- Minimum bus gap between two grants is therefore 2 cycles: one in TURN, one for the IDLE arbitration edge.

Fairness:
- ptr advances past every winner, so with all N requesting, grants rotate 0,1,…,N-1,0.
- A preempted requester that still holds req is granted again only after every other active requester has been served.
- A preempted requester that is the sole requester is re-granted after the gap.

Invariants:
- gnt is never multi-hot.
- busy == |gnt.
- timeout is never high in the same cycle as gnt.
- owner keeps its last value while in IDLE and TURN.

Decomposition:
- Package sr_arb_pkg holds:
  - state encodings IDLE=2'd0, GRANT=2'd1, TURN=2'd2;
  - default N and MAX_HOLD constants.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req[N], ptr.
  - Outputs: found and win index.
  - Implemented as a rotate, fixed-priority select, then rotate back.
- The FSM, counter and registers live in sr_grant_arbiter.

Test Plan (all with N=4, MAX_HOLD=8):
1. Reset: rst=1 with req=4'b1111 and clock running → gnt=0, busy=0, owner=0, timeout=0 throughout. Releasing rst → gnt=4'b0001 after the first edge.
2. Single requester: req=4'b0100 held 3 cycles then dropped → gnt=4'b0100 for 3 cycles, owner=2, then gnt=0 for 2 cycles, busy tracks gnt.
3. Rotation: req=4'b1111 with each owner dropping its bit after 2 grant cycles and re-raising it during TURN → owner sequence 0,1,2,3,0, with a 2-cycle gap between grants.
4. Watchdog: req=4'b0010 held continuously → gnt=4'b0010 for exactly 8 cycles, timeout=1 for 1 cycle, gap, then re-grant to 1.
   - Same test with req=4'b0011 → after the timeout, grant goes to 0 then 1, confirming fairness.
5. Async reset mid-grant: assert rst between edges while gnt=4'b1000 → gnt=0 before the next edge, ptr=0, so the next grant with req=4'b1001 goes to 0.
6. Ignore others: owner=1 granted, then req changes to 4'b1110 → gnt stays 4'b0010 until req[1] drops, then the next grant goes to 2 (not 3).
